// File: rtl/frame_rx_pkg.sv
// Shared constants, frame-buffer types and the row one-hot decoder for the
// LED-matrix serial link receiver.
package frame_rx_pkg;

  localparam int WORD_W = 16;
  localparam int ROWS   = 6;
  localparam int COLS   = 8;
  localparam int DENS_W = 2;
  localparam int PASSES = 4;

  typedef logic [DENS_W-1:0] density_t;
  typedef density_t [ROWS-1:0][COLS-1:0] fb_t;

  typedef struct packed {
    logic       valid;  // exactly one bit set
    logic       multi;  // two or more bits set
    logic [2:0] idx;    // lowest set bit, 0 when none
  } onehot_idx_t;

  function automatic onehot_idx_t onehot_to_idx(input logic [ROWS-1:0] v);
    onehot_idx_t r;
    logic [2:0]  cnt;
    r   = '0;
    cnt = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.idx = 3'(i);
        cnt   = cnt + 3'd1;
      end
    end
    r.valid = (cnt == 3'd1);
    r.multi = (cnt >= 3'd2);
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_sclk_sync.sv
// Brings sclk/serial_data into the clk domain and flags each sclk falling
// edge with a registered pulse and the data bit aligned to it.
module sclk_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic serial_data,
  output logic fall,
  output logic data_s
);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic data_s1, data_s2;

  // NOTE: every flop here is assigned with <= so all stages sample the
  // pre-edge values; blocking assignments would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      fall    <= 1'b0;
      data_s  <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      data_s1 <= serial_data;
      data_s2 <= data_s1;
      fall    <= sclk_s3 & ~sclk_s2;
      data_s  <= data_s2;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Deserializes the scanner's 16-bit word stream and decodes row/column bits.
// Define DENSITY_DECODE_EN to also rebuild the 6x8 2-bit frame buffer.
module serial_frame_receiver
  import frame_rx_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              serial_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [2:0]        row_sel,
  output logic              row_active,
  output logic              fmt_err,
  output logic              resync
`ifdef DENSITY_DECODE_EN
  ,
  output fb_t               fb,
  output logic              frame_valid
`endif
);

  localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic              fall, data_s;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [3:0]        bit_cnt;
  logic [4:0]        word_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic              word_done, timeout;
  onehot_idx_t       row_dec;

  sclk_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .serial_data (serial_data),
    .fall        (fall),
    .data_s      (data_s)
  );

  always_comb begin
    shreg_next = {data_s, shreg[WORD_W-1:1]};
    word_done  = fall && (bit_cnt == 4'd15);
    // A falling edge in the same cycle keeps the link alive, so it wins.
    timeout    = !fall && (idle_cnt == IDLE_LAST);
    row_dec    = onehot_to_idx(shreg_next[13:8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_idx   <= '0;
      idle_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      row_sel    <= '0;
      row_active <= 1'b0;
      fmt_err    <= 1'b0;
      resync     <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      fmt_err    <= 1'b0;
      resync     <= 1'b0;

      if (fall)                     idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);

      if (fall) begin
        shreg   <= shreg_next;
        bit_cnt <= bit_cnt + 4'd1;  // wraps 15 -> 0 on word completion
        if (word_done) begin
          word       <= shreg_next;
          word_valid <= 1'b1;
          row_sel    <= row_dec.idx;
          row_active <= row_dec.valid;
          fmt_err    <= row_dec.multi || (|shreg_next[15:14]);
          word_idx   <= word_idx + 5'd1;
        end
      end else if (timeout) begin
        resync   <= 1'b1;
        bit_cnt  <= '0;
        word_idx <= '0;
        shreg    <= '0;
      end
    end
  end

`ifdef DENSITY_DECODE_EN
  fb_t  acc, acc_next;
  logic frame_end;

  // NOTE: acc_next gets a full default before any conditional update so the
  // block stays purely combinational with no inferred latch.
  always_comb begin
    acc_next  = acc;
    frame_end = word_done && (word_idx == 5'd31);
    if (frame_end) acc_next = '0;
    if (word_done && row_dec.valid) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (row_dec.idx == 3'(r) && shreg_next[c] && acc_next[r][c] != '1)
            acc_next[r][c] = acc_next[r][c] + density_t'(1);
        end
      end
    end
    if (timeout) acc_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      fb          <= '0;
      frame_valid <= 1'b0;
    end else begin
      acc         <= acc_next;
      frame_valid <= frame_end;
      if (frame_end) fb <= acc;
    end
  end
`endif

endmodule
